// File: rtl/decoder_pkg.sv
// Shared mode encodings for the registered select decoder.
package decoder_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DECODE = 2'b00;
  localparam mode_t MODE_THERM  = 2'b01;
  localparam mode_t MODE_SCAN   = 2'b10;
  localparam mode_t MODE_RSVD   = 2'b11;
endpackage

// File: rtl/decoder_seq_if.sv
// Control/result bundle of decoder_seq; master drives controls, slave is the decoder.
interface decoder_seq_if #(
  parameter int SEL_W = 3,
  parameter int DW_W  = 8
) ();
  import decoder_pkg::*;
  localparam int OUT_W = 1 << SEL_W;

  logic             en;
  mode_t            mode;
  logic             load;
  logic [SEL_W-1:0] sel;
  logic [DW_W-1:0]  dwell;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             scan_wrap;

  modport master (output en, mode, load, sel, dwell, input out, out_valid, scan_wrap);
  modport slave  (input en, mode, load, sel, dwell, output out, out_valid, scan_wrap);
endinterface

// File: rtl/decoder_seq_dec_lines.sv
// Shared one-hot / thermometer line generator, one comparator per output line.
module dec_lines #(
  parameter int SEL_W = 3,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  input  logic             therm,
  output logic [OUT_W-1:0] lines
);
  for (genvar k = 0; k < OUT_W; k++) begin : g_line
    localparam logic [SEL_W-1:0] K = SEL_W'(k);
    assign lines[k] = therm ? (K <= idx) : (K == idx);
  end
endmodule

// File: rtl/decoder_seq.sv
// Registered SEL_W-to-2^SEL_W decoder with one-hot, thermometer and dwell-timed SCAN modes.
module decoder_seq #(
  parameter int SEL_W = 3,
  parameter int DW_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  decoder_seq_if.slave bus
);
  import decoder_pkg::*;
  localparam int OUT_W = 1 << SEL_W;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DW_W-1:0]  cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             wrap_d;
  mode_t            mode_q;
  logic [OUT_W-1:0] lines_d, out_q;
  logic             ov_q, wrap_q;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    wrap_d = 1'b0;
    if (!bus.en) begin
      idx_d = '0;
      cnt_d = '0;
      vld_d = 1'b0;
    end else if (bus.load) begin
      idx_d = bus.sel;
      cnt_d = '0;
      vld_d = 1'b1;
    end else if (bus.mode != mode_q) begin
      cnt_d = '0;
    end else if (bus.mode == MODE_SCAN && vld_q) begin
      // cnt is free-running modulo 2^DW_W, so a lowered dwell is caught after wrap
      if (cnt_q == bus.dwell) begin
        cnt_d  = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == {SEL_W{1'b1}});
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Decode the next index so a load shows up at the same edge it is captured
  dec_lines #(.SEL_W(SEL_W)) u_lines (
    .idx   (idx_d),
    .therm (bus.mode == MODE_THERM),
    .lines (lines_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      mode_q <= MODE_DECODE;
      out_q  <= '1;
      ov_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      mode_q <= bus.mode;
      out_q  <= !bus.en ? '1 : (vld_d ? lines_d : '0);
      ov_q   <= vld_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.scan_wrap = wrap_q;
endmodule

// File: tb/tb_decoder_seq.sv
// Randomized + directed bench for decoder_seq at SEL_W=3/DW_W=8 and SEL_W=4/DW_W=3.
module tb_decoder_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_seq_if #(.SEL_W(3), .DW_W(8)) ia ();
  decoder_seq_if #(.SEL_W(4), .DW_W(3)) ib ();

  decoder_seq #(.SEL_W(3), .DW_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  decoder_seq #(.SEL_W(4), .DW_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int total = 0;
  int bad = 0;

  // reference model state per unit (0 = 3-bit, 1 = 4-bit)
  int m_idx[2], m_cnt[2], m_vld[2], m_mode[2];
  logic [31:0] e_out[2];
  logic [31:0] e_ov[2], e_wr[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u] = 0; m_cnt[u] = 0; m_vld[u] = 0; m_mode[u] = 0;
      e_out[u] = (u == 0) ? 32'hFF : 32'hFFFF;
      e_ov[u] = 0; e_wr[u] = 0;
    end
  endtask

  task automatic model_clk(input int u, input int sw, input int dw, input bit en,
                           input int mode, input bit load, input int sel, input int dwell);
    int ow;
    ow = 1 << sw;
    e_wr[u] = 0;
    if (!en) begin
      m_idx[u] = 0; m_cnt[u] = 0; m_vld[u] = 0;
    end else if (load) begin
      m_idx[u] = sel; m_cnt[u] = 0; m_vld[u] = 1;
    end else if (mode != m_mode[u]) begin
      m_cnt[u] = 0;
    end else if (mode == 2 && m_vld[u] == 1) begin
      if (m_cnt[u] == dwell) begin
        m_cnt[u] = 0;
        if (m_idx[u] == ow - 1) e_wr[u] = 1;
        m_idx[u] = (m_idx[u] + 1) % ow;
      end else begin
        m_cnt[u] = (m_cnt[u] + 1) % (1 << dw);
      end
    end else begin
      m_cnt[u] = 0;
    end
    m_mode[u] = mode;
    if (!en) e_out[u] = (32'd1 << ow) - 1;
    else if (m_vld[u] == 0) e_out[u] = 0;
    else if (mode == 1) e_out[u] = (32'd1 << (m_idx[u] + 1)) - 1;
    else e_out[u] = 32'd1 << m_idx[u];
    e_ov[u] = (en && m_vld[u] == 1) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("a_out", 32'(ia.out), e_out[0]);
    chk("a_valid", 32'(ia.out_valid), e_ov[0]);
    chk("a_wrap", 32'(ia.scan_wrap), e_wr[0]);
    chk("b_out", 32'(ib.out), e_out[1]);
    chk("b_valid", 32'(ib.out_valid), e_ov[1]);
    chk("b_wrap", 32'(ib.scan_wrap), e_wr[1]);
  endtask

  // inputs change on the falling edge; outputs checked on the next falling edge
  task automatic step(input bit en, input int mode, input bit load, input int sel, input int dwell);
    ia.en = en; ia.mode = 2'(mode); ia.load = load; ia.sel = 3'(sel % 8); ia.dwell = 8'(dwell % 256);
    ib.en = en; ib.mode = 2'(mode); ib.load = load; ib.sel = 4'(sel % 16); ib.dwell = 3'(dwell % 8);
    @(posedge clk);
    model_clk(0, 3, 8, en, mode, load, sel % 8, dwell % 256);
    model_clk(1, 4, 3, en, mode, load, sel % 16, dwell % 8);
    @(negedge clk);
    check_all();
  endtask

  logic [7:0] t3_out [8] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01};

  initial begin
    int last_wrap, nwrap, cyc;
    ia.en = 0; ia.mode = 0; ia.load = 0; ia.sel = 0; ia.dwell = 0;
    ib.en = 0; ib.mode = 0; ib.load = 0; ib.sel = 0; ib.dwell = 0;
    model_reset();
    #12;
    chk("rst_out", 32'(ia.out), 32'hFF);
    chk("rst_valid", 32'(ia.out_valid), 0);
    chk("rst_wrap", 32'(ia.scan_wrap), 0);
    @(negedge clk); rst_n = 1'b1;

    // basic decode, then disable
    step(1, 0, 1, 5, 0);
    chk("t1_out", 32'(ia.out), 32'h20);
    chk("t1_valid", 32'(ia.out_valid), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_dis", 32'(ia.out), 32'hFF);
    chk("t1_dis_v", 32'(ia.out_valid), 0);

    // thermometer
    step(1, 1, 1, 3, 0); chk("t2_3", 32'(ia.out), 32'h0F);
    step(1, 1, 1, 7, 0); chk("t2_7", 32'(ia.out), 32'hFF);
    step(1, 1, 1, 0, 0); chk("t2_0", 32'(ia.out), 32'h01);

    // scan dwell=2 from 6 through the wrap
    step(1, 2, 1, 6, 2);
    chk("t3_out0", 32'(ia.out), 32'(t3_out[0]));
    for (int i = 1; i < 8; i++) begin
      step(1, 2, 0, 0, 2);
      chk("t3_out", 32'(ia.out), 32'(t3_out[i]));
      chk("t3_wrap", 32'(ia.scan_wrap), (i == 6) ? 1 : 0);
    end

    // load beats a due step
    step(1, 2, 1, 1, 0);
    step(1, 2, 1, 2, 0);
    chk("t4_load", 32'(ia.out), 32'h04);
    chk("t4_wrap", 32'(ia.scan_wrap), 0);
    step(1, 2, 0, 0, 0);
    chk("t4_next", 32'(ia.out), 32'h08);

    // async reset mid-dwell
    step(1, 2, 1, 0, 5);
    step(1, 2, 0, 0, 5);
    step(1, 2, 0, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out", 32'(ia.out), 32'hFF);
    chk("t5_rst_v", 32'(ia.out_valid), 0);
    chk("t5_rst_b", 32'(ib.out), 32'hFFFF);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 0, 0, 5);
      chk("t5_idle", 32'(ia.out), 32'h00);
    end

    // wide instance: top line and 128-cycle wrap period
    step(1, 0, 1, 15, 7);
    chk("t6_top", 32'(ib.out), 32'h8000);
    last_wrap = -1; nwrap = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      step(1, 2, 0, 0, 7);
      if (ib.scan_wrap) begin
        if (last_wrap >= 0) chk("t6_period", 32'(cyc - last_wrap), 128);
        last_wrap = cyc;
        nwrap++;
      end
    end
    chk("t6_nwrap", 32'(nwrap >= 2), 1);

    // randomized traffic, mostly-stable mode so scans make progress
    begin
      int mode, dwell;
      mode = 2; dwell = 1;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 3);
        if ($urandom_range(0, 31) == 0) dwell = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
        step($urandom_range(0, 19) != 0, mode, $urandom_range(0, 9) == 0, $urandom_range(0, 15), dwell);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
